// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the instruction fetch path.
//   fetch_state_t  fetch sequencer state encoding
//   NOP_WORD       value held in the IF/ID buffer when it has not been loaded
//   INSTR_BYTES    instruction width in bytes (pc increment)
//   fetch_addr_bad helper that flags misaligned or out-of-range fetch addresses
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam int          INSTR_BYTES = 4;

    // An address is unusable when it is not word aligned or when the word
    // starting there would run past the end of memory. Comparing against the
    // last legal word address also catches addresses produced by pc wrap.
    function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                            input logic [31:0] last_addr);
        return (addr[1:0] != 2'b00) || (addr > last_addr);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter controller for a byte-addressed,
// combinationally read instruction memory. Each fetched word is captured in a
// one-entry IF/ID buffer handed to decode with a valid/ready handshake.
// Redirects flush the buffer; bad fetch addresses trap into a sticky fault.
//
// Ports:
//   clk              clock, all state on rising edge
//   reset            synchronous active-high reset
//   start            leave IDLE and begin fetching (IDLE only)
//   imem_addr        fetch address to memory (= pc)
//   imem_instr       word returned by memory for imem_addr
//   if_valid         IF/ID buffer holds an instruction
//   if_ready         decode accepts the buffer this cycle
//   if_instr         buffered instruction
//   if_pc            address of buffered instruction
//   if_pc_plus4      if_pc + 4
//   redirect_valid   branch/jump: pc must change to redirect_target
//   redirect_target  new pc
//   fetch_count      completed handshakes (wraps)
//   fault            sticky fetch fault
//   fault_addr       address that caused the fault
//
// State table:
//   ST_IDLE  | waiting for start, buffer empty, redirects ignored
//   ST_FETCH | fetching one word per cycle into the IF/ID buffer
//   ST_FAULT | bad fetch address seen; frozen until reset
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] fetch_count,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - INSTR_BYTES);
    localparam logic [31:0] PC_STEP   = 32'(INSTR_BYTES);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         handshake;

    assign handshake   = if_valid && if_ready;
    assign imem_addr   = pc;
    assign if_pc_plus4 = if_pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= NOP_WORD;
            if_pc       <= 32'h0;
            fetch_count <= 32'h0;
            fault       <= 1'b0;
            fault_addr  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if_valid <= 1'b0;
                    if (start) begin
                        state <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    // The handshake completes even when a redirect flushes
                    // the buffer in the same cycle.
                    if (handshake) begin
                        fetch_count <= fetch_count + 32'd1;
                    end

                    if (redirect_valid) begin
                        // Nothing is loaded this edge: one bubble per redirect.
                        if_valid <= 1'b0;
                        if (fetch_addr_bad(redirect_target, LAST_ADDR)) begin
                            state      <= ST_FAULT;
                            fault      <= 1'b1;
                            fault_addr <= redirect_target;
                        end else begin
                            pc <= redirect_target;
                        end
                    end else if (!if_valid || handshake) begin
                        if (fetch_addr_bad(pc, LAST_ADDR)) begin
                            state      <= ST_FAULT;
                            fault      <= 1'b1;
                            fault_addr <= pc;
                            if_valid   <= 1'b0;
                        end else begin
                            if_instr <= imem_instr;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= pc + PC_STEP;
                        end
                    end
                    // Otherwise decode is stalling: hold pc and the buffer.
                end

                ST_FAULT: begin
                    if_valid <= 1'b0;
                end

                default: begin
                    state    <= ST_IDLE;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed tests for fetch_sequencer with a big-endian
// byte-array instruction memory read combinationally.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] fetch_count;
    logic        fault;
    logic [31:0] fault_addr;

    int passed = 0;
    int total  = 0;

    logic [7:0] mem [128];

    fetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(128)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_count     (fetch_count),
        .fault           (fault),
        .fault_addr      (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_instr = 32'h0;
        if (imem_addr <= 32'd124) begin
            imem_instr = {mem[imem_addr[6:0]], mem[imem_addr[6:0] + 7'd1],
                          mem[imem_addr[6:0] + 7'd2], mem[imem_addr[6:0] + 7'd3]};
        end
    end

    function automatic logic [31:0] word_at(input int a);
        case (a)
            0:       return 32'h2002_0001;
            4:       return 32'h2003_0002;
            8:       return 32'h0000_0000;
            12:      return 32'h0103_4020;
            16:      return 32'h2004_0004;
            default: return 32'hA000_0000 | 32'(a);
        endcase
    endfunction

    task automatic load_mem();
        logic [31:0] w;
        for (int a = 0; a < 128; a += 4) begin
            w = word_at(a);
            mem[a]     = w[31:24];
            mem[a + 1] = w[23:16];
            mem[a + 2] = w[15:8];
            mem[a + 3] = w[7:0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        step();
        reset = 1'b0;
    endtask

    // reset, start and if_ready=1; returns with if_pc=0 valid in the buffer
    task automatic begin_run();
        do_reset();
        if_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        if_ready = 1'b0;
        do_reset();
        total++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid); else passed++;
        total++; if (fetch_count !== 32'h0) $display("FAIL reset_count: got %h want 0", fetch_count); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else passed++;
        total++; if (fault !== 1'b0 || fault_addr !== 32'h0) $display("FAIL reset_fault: got %b/%h want 0/0", fault, fault_addr); else passed++;
        total++; if (if_instr !== 32'h0 || if_pc !== 32'h0) $display("FAIL reset_buf: got %h/%h want 0/0", if_instr, if_pc); else passed++;
        // IDLE ignores redirects and does not fetch
        redirect_valid = 1'b1;
        redirect_target = 32'h20;
        step();
        step();
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'h0 || if_valid !== 1'b0) $display("FAIL idle_hold: got addr %h valid %b want 0/0", imem_addr, if_valid); else passed++;
    endtask

    task automatic test_sequential();
        do_reset();
        if_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (if_valid !== 1'b0) $display("FAIL seq_first_edge: got %b want 0", if_valid); else passed++;
        step();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== word_at(4 * i))
                $display("FAIL seq_word%0d: got v=%b pc=%h instr=%h want 1/%h/%h",
                         i, if_valid, if_pc, if_instr, 32'(4 * i), word_at(4 * i));
            else passed++;
            total++; if (if_pc_plus4 !== 32'(4 * i + 4)) $display("FAIL seq_pc4_%0d: got %h want %h", i, if_pc_plus4, 32'(4 * i + 4)); else passed++;
            step();
        end
        total++; if (fetch_count !== 32'd5) $display("FAIL seq_count: got %0d want 5", fetch_count); else passed++;
    endtask

    task automatic test_stall();
        begin_run();
        step();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h2003_0002 || imem_addr !== 32'h8)
                $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h addr=%h want 1/4/20030002/8",
                         i, if_valid, if_pc, if_instr, imem_addr);
            else passed++;
        end
        total++; if (fetch_count !== 32'd1) $display("FAIL stall_count: got %0d want 1", fetch_count); else passed++;
        if_ready = 1'b1;
        step();
        total++; if (if_pc !== 32'h8 || if_instr !== 32'h0 || if_valid !== 1'b1) $display("FAIL stall_release: got pc=%h instr=%h v=%b want 8/0/1", if_pc, if_instr, if_valid); else passed++;
        total++; if (fetch_count !== 32'd2) $display("FAIL stall_release_count: got %0d want 2", fetch_count); else passed++;
    endtask

    task automatic test_redirect_and_fault();
        begin_run();
        step();
        redirect_valid = 1'b1;
        redirect_target = 32'h10;
        step();
        redirect_valid = 1'b0;
        total++; if (fetch_count !== 32'd2) $display("FAIL redir_count: got %0d want 2", fetch_count); else passed++;
        total++; if (if_valid !== 1'b0 || imem_addr !== 32'h10) $display("FAIL redir_bubble: got v=%b addr=%h want 0/10", if_valid, imem_addr); else passed++;
        step();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'h2004_0004) $display("FAIL redir_target: got v=%b pc=%h instr=%h want 1/10/20040004", if_valid, if_pc, if_instr); else passed++;
        total++; if (if_pc_plus4 !== 32'h14) $display("FAIL redir_pc4: got %h want 14", if_pc_plus4); else passed++;
        // misaligned redirect traps
        redirect_valid = 1'b1;
        redirect_target = 32'h6;
        step();
        total++; if (fault !== 1'b1 || fault_addr !== 32'h6 || if_valid !== 1'b0) $display("FAIL misalign_fault: got f=%b addr=%h v=%b want 1/6/0", fault, fault_addr, if_valid); else passed++;
        total++; if (fetch_count !== 32'd3) $display("FAIL misalign_count: got %0d want 3", fetch_count); else passed++;
        // sticky: start and redirect ignored
        start = 1'b1;
        redirect_target = 32'h20;
        step();
        step();
        start = 1'b0;
        redirect_valid = 1'b0;
        total++;
        if (fault !== 1'b1 || fault_addr !== 32'h6 || if_valid !== 1'b0 || imem_addr !== 32'h14 || fetch_count !== 32'd3)
            $display("FAIL fault_sticky: got f=%b fa=%h v=%b addr=%h cnt=%0d want 1/6/0/14/3",
                     fault, fault_addr, if_valid, imem_addr, fetch_count);
        else passed++;
        do_reset();
        total++; if (fault !== 1'b0 || fault_addr !== 32'h0 || imem_addr !== 32'h0) $display("FAIL fault_reset: got f=%b fa=%h addr=%h want 0/0/0", fault, fault_addr, imem_addr); else passed++;
    endtask

    task automatic test_redirect_range();
        begin_run();
        if_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h7C;
        step();
        redirect_valid = 1'b0;
        total++; if (fetch_count !== 32'd0 || if_valid !== 1'b0 || imem_addr !== 32'h7C) $display("FAIL range_last: got cnt=%0d v=%b addr=%h want 0/0/7c", fetch_count, if_valid, imem_addr); else passed++;
        step();
        total++; if (if_pc !== 32'h7C || if_instr !== 32'hA000_007C || if_valid !== 1'b1) $display("FAIL range_last_word: got pc=%h instr=%h v=%b want 7c/a000007c/1", if_pc, if_instr, if_valid); else passed++;
        redirect_valid = 1'b1;
        redirect_target = 32'h80;
        step();
        redirect_valid = 1'b0;
        total++; if (fault !== 1'b1 || fault_addr !== 32'h80) $display("FAIL range_over: got f=%b fa=%h want 1/80", fault, fault_addr); else passed++;
    endtask

    task automatic test_end_of_memory();
        begin_run();
        for (int k = 0; k < 32; k++) begin
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== word_at(4 * k))
                $display("FAIL eom_word%0d: got v=%b pc=%h instr=%h want 1/%h/%h",
                         k, if_valid, if_pc, if_instr, 32'(4 * k), word_at(4 * k));
            else passed++;
            step();
        end
        total++; if (fault !== 1'b1 || fault_addr !== 32'h80 || if_valid !== 1'b0) $display("FAIL eom_fault: got f=%b fa=%h v=%b want 1/80/0", fault, fault_addr, if_valid); else passed++;
        total++; if (fetch_count !== 32'd32) $display("FAIL eom_count: got %0d want 32", fetch_count); else passed++;
    endtask

    task automatic test_reset_during_stall();
        begin_run();
        step();
        if_ready = 1'b0;
        step();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h4) $display("FAIL rst_stall_pre: got v=%b pc=%h want 1/4", if_valid, if_pc); else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (if_valid !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 32'h0) $display("FAIL rst_stall: got v=%b cnt=%0d addr=%h want 0/0/0", if_valid, fetch_count, imem_addr); else passed++;
        step();
        total++; if (if_valid !== 1'b0) $display("FAIL rst_stall_idle: got v=%b want 0", if_valid); else passed++;
        if_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h2002_0001) $display("FAIL rst_restart: got v=%b pc=%h instr=%h want 1/0/20020001", if_valid, if_pc, if_instr); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        load_mem();
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_and_fault();
        test_redirect_range();
        test_end_of_memory();
        test_reset_during_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller that sequences the byte-addressed, combinational-read instruction memory (128 bytes, big-endian 4-byte fetch).
- Drives the fetch address and registers each fetched word into a one-entry IF/ID output buffer with a valid/ready handshake to decode.
- Handles decode stalls and branch/jump redirects with flush.
- Traps misaligned or out-of-range fetches into a sticky fault state.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_BYTES, 128, instruction memory size in bytes; the last legal fetch address is MEM_BYTES-4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching; ignored outside IDLE.
- imem_addr  output  32  fetch address to instruction memory; always equals current pc.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- if_valid  output  1  output buffer holds an instruction.
- if_ready  input  1  decode accepts the buffer this cycle.
- if_instr  output  32  buffered instruction.
- if_pc  output  32  address of the buffered instruction.
- if_pc_plus4  output  32  if_pc + 4, for link/branch computation.
- redirect_valid  input  1  branch taken or jump; pc must change.
- redirect_target  input  32  new pc.
- fetch_count  output  32  number of completed handshakes (if_valid && if_ready).
- fault  output  1  sticky fetch fault.
- fault_addr  output  32  offending address.

Behaviour:
- Reset values (synchronous reset): state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_count=0, fault=0, fault_addr=0.
- Reset asserted mid-operation overrides everything at that edge; any buffered instruction is lost.
- States: IDLE, FETCH, FAULT.
- IDLE:
  - if_valid=0; redirect_valid is ignored.
  - If start=1 at edge: go to FETCH; pc is unchanged.
- FETCH, evaluated each edge in this priority:
  1. Handshake: if if_valid && if_ready, fetch_count += 1 (wraps modulo 2^32). This always completes, even on a redirect cycle.
  2. Redirect: if redirect_valid:
     - if_valid <= 0 (flush, whether or not the handshake fired).
     - If redirect_target[1:0] != 0 or redirect_target > MEM_BYTES-4: go to FAULT, fault <= 1, fault_addr <= redirect_target.
     - Otherwise pc <= redirect_target.
     - No word is loaded this edge, giving a 1-bubble redirect penalty.
  3. Load: when the buffer is free (if_valid=0 or the handshake fired):
     - If pc > MEM_BYTES-4 or pc[1:0] != 0: go to FAULT, fault <= 1, fault_addr <= pc, if_valid <= 0.
     - Otherwise if_instr <= imem_instr, if_pc <= pc, if_valid <= 1, pc <= pc + 4.
  4. Stall: if if_valid && !if_ready and no redirect, hold pc and all buffer outputs stable.
- Throughput: 1 instruction/cycle while if_ready=1.
- Latency: start sampled high at edge E gives FETCH at E; first if_valid=1 at E+1 with if_pc=RESET_PC.
- FAULT:
  - if_valid=0; pc frozen; start and redirect ignored.
  - Exit only via reset.
- Combinational outputs: imem_addr=pc; if_pc_plus4=if_pc+4.
- Arithmetic: pc and if_pc_plus4 are 32-bit with natural wrap. The range check catches wrap before any fetch occurs.

Decomposition:
- Shared package mips_pkg:
  - fetch state encoding (IDLE=2'd0, FETCH=2'd1, FAULT=2'd2).
  - NOP_WORD=32'h0000_0000.
  - INSTR_BYTES=4.
- No sub-module; the memory instance lives at the datapath top and connects via imem_addr/imem_instr.

Test Plan:
1. Memory preloaded with 0x20020001, 0x20030002, 0x00000000, 0x01034020, 0x20040004; reset, start, if_ready=1 -> five handshakes with if_pc 0,4,8,12,16, matching words, fetch_count=5.
2. if_ready=0 for 3 cycles while if_valid=1, if_pc=4 -> if_instr=0x20030002 and imem_addr=8 held stable; on release, next word is if_pc=8.
3. redirect_valid=1 with redirect_target=0x10 while if_pc=4 is valid and if_ready=1 -> fetch_count increments, one bubble cycle (if_valid=0), then if_pc=0x10, if_instr=0x20040004.
4. redirect_target=0x06 -> fault=1, fault_addr=0x06, if_valid stays 0; later start/redirect do nothing until reset.
5. Sequential run to pc=124 with if_ready=1 -> word at 124 delivered, then fault=1, fault_addr=128.
6. Reset asserted during a stall in FETCH -> next cycle state=IDLE, if_valid=0, fetch_count=0, imem_addr=RESET_PC; start restarts at 0.
